// File: rtl/alu_ctrl_pkg.sv
// Shared ALUControl encoding and execution-unit FSM state type.
// The ALU decoder imports the same constants so both sides agree on the code.
package alu_ctrl_pkg;

    localparam int unsigned ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, fixed DATA_WIDTH iterations.
// done_c/product_c are combinational so the caller can register the product on the final iteration edge.
module seq_multiplier #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_c,
    output logic [DATA_WIDTH-1:0] product_c
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PROD_W-1:0]     mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [PROD_W-1:0]     acc_q, acc_d;
    logic [PROD_W-1:0]     acc_step_c;

    assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done_c     = busy_q && (cnt_q == LAST_ITER);
    assign product_c  = acc_step_c[DATA_WIDTH-1:0];

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = PROD_W'(a_i);
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready handshake around single-cycle logic/add/sub/slt
// and a DATA_WIDTH-cycle sequential multiply.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [CTRL_WIDTH-1:0] ALUControl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic [DATA_WIDTH-1:0] alu_result_c;
    logic                  accept_c;
    logic                  is_mul_c;
    logic                  mul_start_c;
    logic                  mul_done_c;
    logic [DATA_WIDTH-1:0] mul_product_c;

    assign accept_c = in_valid && (state_q == ST_IDLE) && !RST;
    assign is_mul_c = (ALUControl == ALU_MUL);

    // Single-cycle operations; undefined codes yield zero.
    always_comb begin
        alu_result_c = '0;
        case (ALUControl)
            ALU_AND: alu_result_c = SrcA & SrcB;
            ALU_OR:  alu_result_c = SrcA | SrcB;
            ALU_ADD: alu_result_c = SrcA + SrcB;
            ALU_SUB: alu_result_c = SrcA - SrcB;
            ALU_SLT: alu_result_c = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            default: alu_result_c = '0;
        endcase
    end

    seq_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk_i     (CLK),
        .rst_i     (RST),
        .start_i   (mul_start_c),
        .a_i       (SrcA),
        .b_i       (SrcB),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = is_mul_c ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done_c) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result capture happens on the accept edge or the final multiply iteration.
    always_comb begin
        in_ready    = (state_q == ST_IDLE) && !RST;
        out_valid   = (state_q == ST_DONE);
        mul_start_c = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c) begin
                        mul_start_c = 1'b1;
                    end else begin
                        result_d = alu_result_c;
                        zero_d   = (alu_result_c == '0);
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    result_d = mul_product_c;
                    zero_d   = (mul_product_c == '0);
                end
            end
            default: ;
        endcase
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit: handshake, latency, arithmetic corners, reset abort.
module tb_alu_exec_unit;
    import alu_ctrl_pkg::*;

    localparam int unsigned W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [2:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];

    alu_exec_unit #(.DATA_WIDTH(W), .CTRL_WIDTH(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    always #5 CLK = ~CLK;

    // Reference model: {zero, result}
    function automatic logic [W:0] model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (c)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b100:  r = a - b;
            3'b101:  r = a * b;
            3'b110:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input bit push, input bit hold);
        SrcA       = a;
        SrcB       = b;
        ALUControl = c;
        in_valid   = 1'b1;
        check("in_ready_at_accept", 64'(in_ready), 64'd1);
        if (push) exp_q.push_back(exp);
        tick();
        in_valid   = hold;
        SrcA       = $urandom;
        SrcB       = $urandom;
        ALUControl = hold ? ALU_ADD : 3'($urandom);
    endtask

    task automatic wait_result(input int exp_lat, input string tag);
        int lat;
        logic [W:0] e;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_valid) check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'(ALUResult), 64'(e[W-1:0]));
            check({tag, "_zero"}, 64'(Zero), 64'(e[W]));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   ops [5];
        int           seen;
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};

        // Reset held two cycles
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = '0; SrcB = '0; ALUControl = '0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        RST = 1'b0;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(ALUResult), 64'd0);
        check("rst_zero", 64'(Zero), 64'd0);
        check("rst_in_ready_after", 64'(in_ready), 64'd1);

        // add/sub wrap
        send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, {1'b1, 32'h0000_0000}, 1'b1, 1'b0);
        wait_result(1, "add_wrap");
        release_out("add_wrap");
        send(ALU_SUB, 32'd5, 32'd7, {1'b0, 32'hFFFF_FFFE}, 1'b1, 1'b0);
        wait_result(1, "sub_wrap");
        release_out("sub_wrap");

        // signed slt
        send(ALU_SLT, 32'hFFFF_FFFF, 32'd1, {1'b0, 32'd1}, 1'b1, 1'b0);
        wait_result(1, "slt_neg");
        release_out("slt_neg");
        send(ALU_SLT, 32'd1, 32'hFFFF_FFFF, {1'b1, 32'd0}, 1'b1, 1'b0);
        wait_result(1, "slt_pos");
        release_out("slt_pos");

        // logic ops and undefined codes
        send(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, {1'b0, 32'hF000_F000}, 1'b1, 1'b0);
        wait_result(1, "and");
        release_out("and");
        send(ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, {1'b0, 32'hF0F0_0F0F}, 1'b1, 1'b0);
        wait_result(1, "or");
        release_out("or");
        send(3'b011, 32'd5, 32'd5, {1'b1, 32'd0}, 1'b1, 1'b0);
        wait_result(1, "undef011");
        release_out("undef011");
        send(3'b111, 32'hFFFF_FFFF, 32'd9, {1'b1, 32'd0}, 1'b1, 1'b0);
        wait_result(1, "undef111");
        release_out("undef111");

        // mul latency with in_valid held high throughout
        send(ALU_MUL, 32'h0001_2345, 32'h0001_0000, {1'b0, 32'h2345_0000}, 1'b1, 1'b1);
        wait_result(W + 1, "mul_lat");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("done_no_accept", 64'(out_valid), 64'd0);
        check("done_no_accept_in_ready", 64'(in_ready), 64'd1);

        // mul with a zero operand still takes the full latency
        send(ALU_MUL, 32'hDEAD_BEEF, 32'd0, {1'b1, 32'd0}, 1'b1, 1'b0);
        wait_result(W + 1, "mul_zero");
        release_out("mul_zero");

        // random multiplies, including signed-looking operands
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            send(ALU_MUL, ra, rb, model(ALU_MUL, ra, rb), 1'b1, 1'b0);
            wait_result(W + 1, "mul_rand");
            release_out("mul_rand");
        end

        // backpressure: result must hold while out_ready is low
        send(ALU_ADD, 32'd100, 32'd23, {1'b0, 32'd123}, 1'b1, 1'b0);
        wait_result(1, "bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_result_hold", 64'(ALUResult), 64'd123);
        end
        release_out("bp");

        // out_ready while idle does nothing
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_valid", 64'(out_valid), 64'd0);
        check("idle_out_ready_in_ready", 64'(in_ready), 64'd1);

        // reset mid-multiply abandons the operation
        send(ALU_MUL, 32'd3, 32'd5, {1'b0, 32'd15}, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        RST = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("mid_rst_no_out_valid", 64'(seen), 64'd0);
        check("mid_rst_idle", 64'(in_ready), 64'd1);
        send(ALU_ADD, 32'd2, 32'd3, {1'b0, 32'd5}, 1'b1, 1'b0);
        wait_result(1, "post_rst_add");
        release_out("post_rst_add");

        // random single-cycle ops against the model
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? ra : 32'($urandom);
            send(ops[i % 5], ra, rb, model(ops[i % 5], ra, rb), 1'b1, 1'b0);
            wait_result(1, "rand_op");
            release_out("rand_op");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
